// File: rtl/synapse_bank_if.sv
// synapse_bank_if - address-stream / weight-stream bundle for synapse_bank.
//
// Address stream (AS): upstream arbiter -> synapse_bank
//   iValid_AS  beat valid
//   oReady_AS  bank can take a beat
//   iData_AS   {ctl[CTL_W-1:0], row[$clog2(NA)-1:0]}
// Weight stream (BS): synapse_bank -> diff-accumulator
//   oValid_BS  beat valid
//   iReady_BS  consumer takes the beat
//   oData_BS   {ctl, w[NB-1] .. w[0]}, column 0 in the LSBs
//
// Modports: slave = the synapse bank, master = the surrounding logic.
interface synapse_bank_if #(
    parameter int NA    = 4,
    parameter int NB    = 4,
    parameter int WD    = 4,
    parameter int CTL_W = 4
) ();
    logic                      iValid_AS;
    logic                      oReady_AS;
    logic [CTL_W+$clog2(NA)-1:0] iData_AS;
    logic                      oValid_BS;
    logic                      iReady_BS;
    logic [CTL_W+NB*WD-1:0]    oData_BS;

    modport slave (
        input  iValid_AS, iData_AS, iReady_BS,
        output oReady_AS, oValid_BS, oData_BS
    );

    modport master (
        output iValid_AS, iData_AS, iReady_BS,
        input  oReady_AS, oValid_BS, oData_BS
    );
endinterface

// File: rtl/synapse_bank.sv
// synapse_bank - NA x NB matrix of WD-bit synapse weights.
//
// A row address arriving on the address stream returns that row's NB weights
// on the weight stream, with the stream's control side-band carried alongside.
// A host port reads/writes single weights through a flat address.
//
// Ports:
//   iCLK, iRST       clock; synchronous active-high reset
//   iWE              host write enable (every cycle with iWE=0 is a host read)
//   iAddr            host flat address, row = iAddr/NB, column = iAddr%NB
//   iData            host write data
//   oData            host read data, one cycle after the read
//   oValid_RD        host read data valid
//   st               synapse_bank_if.slave: address stream in, weight stream out
//   oEvtCnt          (SYNAPSE_BANK_EVT_CNT_EN only) count of delivered beats
//
// Optional feature macro: SYNAPSE_BANK_EVT_CNT_EN adds the oEvtCnt delivery
// counter; without it the port and counter are absent.
//
// Storage is a dual-port RAM with per-column write enables: port A is the
// host, port B serves the stream. Port B's registered read output is the head
// of a 2-entry output buffer; the second entry is a skid register, so
// oReady_AS never depends on iReady_BS. Out-of-range rows/addresses read as 0
// and out-of-range host writes are dropped. A host write and a stream read of
// the same row on one edge are read-first.
//
// RAM contents are not touched by iRST. INIT_FILE names the preload image
// the implementation flow attaches to the weight RAM; empty means all zero.
module synapse_bank #(
    parameter int    NA        = 4,
    parameter int    NB        = 4,
    parameter int    WD        = 4,
    parameter int    CTL_W     = 4,
    parameter string INIT_FILE = ""
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iWE,
    input  logic [$clog2(NA*NB)-1:0] iAddr,
    input  logic [WD-1:0]            iData,
    output logic [WD-1:0]            oData,
    output logic                     oValid_RD,
`ifdef SYNAPSE_BANK_EVT_CNT_EN
    output logic [31:0]              oEvtCnt,
`endif
    synapse_bank_if.slave            st
);

    localparam int AW = $clog2(NA*NB);
    localparam int RW = $clog2(NA);
    localparam int CW = $clog2(NB);

    // Range limits held one bit wider than the index they bound.
    localparam logic [AW:0] N_WORDS = (AW+1)'(NA*NB);
    localparam logic [RW:0] N_ROWS  = (RW+1)'(NA);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [RW-1:0]    h_row;
    logic [CW-1:0]    h_col;
    logic             h_in;
    logic [RW-1:0]    s_row;
    logic [CTL_W-1:0] s_ctl;
    logic             s_in;

    assign h_row = RW'(iAddr / AW'(NB));
    assign h_col = CW'(iAddr % AW'(NB));
    assign h_in  = {1'b0, iAddr} < N_WORDS;

    assign s_row = st.iData_AS[RW-1:0];
    assign s_ctl = st.iData_AS[RW +: CTL_W];
    assign s_in  = {1'b0, s_row} < N_ROWS;

    // ------------------------------------------------------------------
    // Handshakes and occupancy
    // ------------------------------------------------------------------
    logic [1:0] occ;
    logic       q_v;      // port B read register holds a beat
    logic       s_v;      // skid register holds a beat (always the older one)
    logic       accept;
    logic       deliver;
    logic       park;

    assign st.oReady_AS = (occ < 2'd2) && !iRST;
    assign accept       = st.iValid_AS && st.oReady_AS;
    assign deliver      = st.oValid_BS && st.iReady_BS;

    // A presented-but-unconsumed head beat moves aside when a new RAM result
    // is about to overwrite the read register. occ<2 guarantees s_v=0 here.
    assign park = accept && q_v && !deliver;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            occ <= 2'd0;
            q_v <= 1'b0;
            s_v <= 1'b0;
        end else begin
            if (accept && !deliver)
                occ <= occ + 2'd1;
            else if (!accept && deliver)
                occ <= occ - 2'd1;

            // Head is the skid entry when present, otherwise the read register.
            if (accept)
                q_v <= 1'b1;
            else if (deliver && !s_v)
                q_v <= 1'b0;

            if (park)
                s_v <= 1'b1;
            else if (deliver && s_v)
                s_v <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Weight RAM, port A write (host). Nonblocking update gives read-first
    // behaviour against both read ports on the same edge.
    // ------------------------------------------------------------------
    logic [NB-1:0][WD-1:0] mem [NA];

    always_ff @(posedge iCLK) begin
        if (iWE && h_in && !iRST)
            mem[h_row][h_col] <= iData;
    end

    // ------------------------------------------------------------------
    // Port A read (host)
    // ------------------------------------------------------------------
    logic [WD-1:0] rd_q;
    logic          rd_vld;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rd_q   <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= !iWE;
            if (!iWE)
                rd_q <= h_in ? mem[h_row][h_col] : '0;
        end
    end

    assign oData     = iRST ? '0 : rd_q;
    assign oValid_RD = rd_vld && !iRST;

    // ------------------------------------------------------------------
    // Port B read register and skid register (stream data path)
    // ------------------------------------------------------------------
    logic [CTL_W-1:0]      q_ctl;
    logic [NB-1:0][WD-1:0] q_w;
    logic [CTL_W-1:0]      k_ctl;
    logic [NB-1:0][WD-1:0] k_w;

    always_ff @(posedge iCLK) begin
        if (accept) begin
            q_ctl <= s_ctl;
            q_w   <= s_in ? mem[s_row] : '0;
        end
        if (park) begin
            k_ctl <= q_ctl;
            k_w   <= q_w;
        end
    end

    assign st.oValid_BS = (q_v || s_v) && !iRST;
    assign st.oData_BS  = iRST ? '0 : (s_v ? {k_ctl, k_w} : {q_ctl, q_w});

    // ------------------------------------------------------------------
    // Optional delivery counter
    // ------------------------------------------------------------------
`ifdef SYNAPSE_BANK_EVT_CNT_EN
    logic [31:0] evt_cnt;

    always_ff @(posedge iCLK) begin
        if (iRST)
            evt_cnt <= '0;
        else if (deliver)
            evt_cnt <= evt_cnt + 32'd1;   // wraps naturally
    end

    assign oEvtCnt = evt_cnt;
`endif

endmodule

// File: tb/tb_synapse_bank.sv
// Self-checking bench for synapse_bank.
// A negedge monitor keeps a weight-matrix model and a queue of expected beats;
// stimulus (directed scenarios, then random traffic) only drives inputs.
// A second, 3x3 instance exercises out-of-range rows and addresses.
module tb_synapse_bank;

    localparam int NA = 4, NB = 4, WD = 4, CTL_W = 4;
    localparam int AW = $clog2(NA*NB);
    localparam int RW = $clog2(NA);
    localparam int DW = CTL_W + NB*WD;

    localparam int NA2 = 3, NB2 = 3;

    typedef logic [DW-1:0] beat_t;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iWE  = 1'b0;
    logic [AW-1:0] iAddr = '0;
    logic [WD-1:0] iData = '0;
    logic [WD-1:0] oData;
    logic          oValid_RD;

    logic       x_we = 1'b0;
    logic [3:0] x_addr = '0;
    logic [3:0] x_data = '0;
    logic [3:0] x_rdata;
    logic       x_rvld;

`ifdef SYNAPSE_BANK_EVT_CNT_EN
    logic [31:0] evt_cnt;
    logic [31:0] x_evt;
`endif

    synapse_bank_if #(.NA(NA), .NB(NB), .WD(WD), .CTL_W(CTL_W)) bus ();
    synapse_bank_if #(.NA(NA2), .NB(NB2), .WD(WD), .CTL_W(CTL_W)) bus2 ();

    always #5 iCLK = ~iCLK;

    synapse_bank #(.NA(NA), .NB(NB), .WD(WD), .CTL_W(CTL_W), .INIT_FILE("")) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iWE       (iWE),
        .iAddr     (iAddr),
        .iData     (iData),
        .oData     (oData),
        .oValid_RD (oValid_RD),
`ifdef SYNAPSE_BANK_EVT_CNT_EN
        .oEvtCnt   (evt_cnt),
`endif
        .st        (bus.slave)
    );

    synapse_bank #(.NA(NA2), .NB(NB2), .WD(WD), .CTL_W(CTL_W), .INIT_FILE("")) dut2 (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iWE       (x_we),
        .iAddr     (x_addr),
        .iData     (x_data),
        .oData     (x_rdata),
        .oValid_RD (x_rvld),
`ifdef SYNAPSE_BANK_EVT_CNT_EN
        .oEvtCnt   (x_evt),
`endif
        .st        (bus2.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: weight matrix, expected-beat queue, read expectation
    // ------------------------------------------------------------------
    int          model [NA][NB];
    beat_t       exp_q [$];
    logic        exp_rd_v = 1'b0;
    logic [WD-1:0] exp_rd_d = '0;
    logic        hold_p = 1'b0;
    beat_t       hold_d = '0;
    int unsigned evt_m = 0;

    function automatic beat_t row_beat(input int ctl, input int row);
        beat_t b;
        b = '0;
        b[DW-1 -: CTL_W] = CTL_W'(ctl);
        if (row < NA)
            for (int c = 0; c < NB; c++)
                b[c*WD +: WD] = WD'(model[row][c]);
        return b;
    endfunction

    int m_row, m_ctl, m_addr;

    always @(negedge iCLK) begin
        if (iRST) begin
            check("rst_ready_as", bus.oReady_AS, 0);
            check("rst_valid_bs", bus.oValid_BS, 0);
            check("rst_data_bs",  bus.oData_BS, 0);
            check("rst_valid_rd", oValid_RD, 0);
            check("rst_data_rd",  oData, 0);
            exp_q.delete();
            exp_rd_v = 1'b0;
            hold_p   = 1'b0;
            evt_m    = 0;
        end else begin
            // Current outputs against the model.
            check("bs_valid", bus.oValid_BS, exp_q.size() != 0);
            check("as_ready", bus.oReady_AS, exp_q.size() < 2);
            if (hold_p)
                check("bs_hold", bus.oData_BS, hold_d);
`ifdef SYNAPSE_BANK_EVT_CNT_EN
            check("evt_cnt", evt_cnt, evt_m);
`endif
            if (bus.oValid_BS && bus.iReady_BS) begin
                if (exp_q.size() != 0)
                    check("bs_beat", bus.oData_BS, exp_q.pop_front());
                else
                    check("bs_extra_beat", 1, 0);
                evt_m++;
            end
            hold_p = bus.oValid_BS && !bus.iReady_BS;
            hold_d = bus.oData_BS;

            check("rd_valid", oValid_RD, exp_rd_v);
            if (exp_rd_v)
                check("rd_data", oData, exp_rd_d);

            // Effects of the coming edge: stream read sees old weights.
            if (bus.iValid_AS && bus.oReady_AS) begin
                m_row = int'(bus.iData_AS[RW-1:0]);
                m_ctl = int'(bus.iData_AS[RW +: CTL_W]);
                exp_q.push_back(row_beat(m_ctl, m_row));
            end
            m_addr   = int'(iAddr);
            exp_rd_v = !iWE;
            if (!iWE)
                exp_rd_d = (m_addr < NA*NB) ? WD'(model[m_addr / NB][m_addr % NB]) : '0;
            if (iWE && m_addr < NA*NB)
                model[m_addr / NB][m_addr % NB] = int'(iData);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic as_beat(input logic v, input int ctl, input int row);
        bus.iValid_AS = v;
        bus.iData_AS  = {CTL_W'(ctl), RW'(row)};
    endtask

    initial begin
        bus.iValid_AS  = 1'b0;
        bus.iData_AS   = '0;
        bus.iReady_BS  = 1'b0;
        bus2.iValid_AS = 1'b0;
        bus2.iData_AS  = '0;
        bus2.iReady_BS = 1'b1;

        repeat (3) tick();
        iRST = 1'b0;

        // Fill the matrix; addr 5 = row1/col1 = 0xA, addr 8 = row2/col0 = 0x3.
        for (int a = 0; a < NA*NB; a++) begin
            iWE   = 1'b1;
            iAddr = AW'(a);
            iData = (a == 5) ? 4'hA : (a == 8) ? 4'h3 : WD'($urandom);
            tick();
        end
        iWE = 1'b0;
        iAddr = AW'(5);  tick();
        iAddr = AW'(6);  tick();

        // Back-to-back rows 0..3, ctl 1..4, consumer always ready.
        bus.iReady_BS = 1'b1;
        for (int r = 0; r < 4; r++) begin
            as_beat(1'b1, r + 1, r);
            tick();
        end
        as_beat(1'b0, 0, 0);
        repeat (3) tick();

        // Backpressure: only two beats fit, outputs hold, then drain in order.
        bus.iReady_BS = 1'b0;
        for (int i = 0; i < 4; i++) begin
            as_beat(1'b1, 8 + i, i);
            tick();
        end
        as_beat(1'b0, 0, 0);
        repeat (2) tick();
        bus.iReady_BS = 1'b1;
        repeat (3) tick();

        // Same-edge write of row2/col0 (0x3 -> 0xF) and stream read of row 2.
        iWE = 1'b1; iAddr = AW'(8); iData = 4'hF;
        as_beat(1'b1, 5, 2);
        tick();
        iWE = 1'b0;
        as_beat(1'b1, 6, 2);
        tick();
        as_beat(1'b0, 0, 0);
        repeat (2) tick();

        // Reset with the buffer full; nothing may come out afterwards.
        bus.iReady_BS = 1'b0;
        for (int i = 0; i < 3; i++) begin
            as_beat(1'b1, 12 + i, i);
            tick();
        end
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        as_beat(1'b0, 0, 0);
        bus.iReady_BS = 1'b1;
        repeat (3) tick();
        iAddr = AW'(5); tick();
        iAddr = AW'(8); tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            as_beat($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), int'($urandom_range(0, NA-1)));
            bus.iReady_BS = $urandom_range(0, 3) != 0;
            iWE   = $urandom_range(0, 3) == 0;
            iAddr = AW'($urandom_range(0, NA*NB-1));
            iData = WD'($urandom);
            tick();
        end
        as_beat(1'b0, 0, 0);
        iWE = 1'b0;
        bus.iReady_BS = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++)
            tick();
        check("drain", exp_q.size(), 0);

        // 3x3 instance: out-of-range host address and stream row.
        @(negedge iCLK);
        x_we = 1'b1;
        for (int a = 0; a < NA2*NB2; a++) begin
            x_addr = 4'(a);
            x_data = 4'((a*5 + 1) & 15);
            @(negedge iCLK);
        end
        x_addr = 4'd4;  x_data = 4'h7; @(negedge iCLK);
        x_addr = 4'd12; x_data = 4'hE; @(negedge iCLK);
        x_we = 1'b0;
        x_addr = 4'd4;  @(negedge iCLK);
        check("oor_rd_inrange_v", x_rvld, 1);
        check("oor_rd_inrange_d", x_rdata, 4'h7);
        x_addr = 4'd12; @(negedge iCLK);
        check("oor_rd_v", x_rvld, 1);
        check("oor_rd_d", x_rdata, 0);
        x_addr = 4'd0;  @(negedge iCLK);
        check("oor_wr_no_alias", x_rdata, 4'h1);
        bus2.iValid_AS = 1'b1;
        bus2.iData_AS  = {4'hC, 2'd3};
        @(negedge iCLK);
        check("oor_row_v", bus2.oValid_BS, 1);
        check("oor_row_d", bus2.oData_BS, 16'hC000);
        bus2.iData_AS  = {4'h3, 2'd1};
        @(negedge iCLK);
        bus2.iValid_AS = 1'b0;
        check("row1_v", bus2.oValid_BS, 1);
        check("row1_d", bus2.oData_BS, 16'h3A70);
        @(negedge iCLK);
        check("row1_done", bus2.oValid_BS, 0);
`ifdef SYNAPSE_BANK_EVT_CNT_EN
        check("oor_evt_cnt", x_evt, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
